// File: rtl/scpad_unswizzle_pkg.sv
// Shared scratchpad crossbar types plus the lane un-permute and bank-conflict helpers.
package scpad_unswizzle_pkg;

    localparam int NUM_COLS      = 16;
    localparam int COL_IDX_WIDTH = $clog2(NUM_COLS);
    localparam int ROW_IDX_WIDTH = 6;
    localparam int LANE_W        = 16;

    typedef logic [COL_IDX_WIDTH-1:0] col_idx_t;
    typedef logic [ROW_IDX_WIDTH-1:0] row_idx_t;

    typedef struct packed {
        logic [NUM_COLS-1:0]           valid_mask;
        col_idx_t [NUM_COLS-1:0]       shift_mask;
        row_idx_t [NUM_COLS-1:0]       slot_mask;
    } xbar_desc_t;

    // Two valid lanes mapped to the same bank cannot both have been served by one read.
    function automatic logic has_bank_conflict(input xbar_desc_t d);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_COLS; i++) begin
            for (int j = i + 1; j < NUM_COLS; j++) begin
                if (d.valid_mask[i] && d.valid_mask[j] && (d.shift_mask[i] == d.shift_mask[j])) begin
                    hit = 1'b1;
                end
            end
        end
        return hit;
    endfunction

    function automatic logic [NUM_COLS*LANE_W-1:0] unswizzle_lanes(
        input xbar_desc_t                  d,
        input logic [NUM_COLS*LANE_W-1:0]  rdata
    );
        logic [NUM_COLS*LANE_W-1:0] lanes;
        lanes = '0;
        for (int i = 0; i < NUM_COLS; i++) begin
            if (d.valid_mask[i]) begin
                lanes[i*LANE_W +: LANE_W] = rdata[int'(d.shift_mask[i])*LANE_W +: LANE_W];
            end
        end
        return lanes;
    endfunction

endpackage

// File: rtl/scpad_unswizzle_if.sv
// Descriptor issue, bank return and logical output channels of the scratchpad read-return path.
interface scpad_unswizzle_if
    import scpad_unswizzle_pkg::*;
#(
    parameter int DATA_W = 16
);
    logic                       desc_valid;
    logic                       desc_ready;
    xbar_desc_t                 desc;
    logic                       bank_rvalid;
    logic [NUM_COLS*DATA_W-1:0] bank_rdata;
    logic                       out_valid;
    logic                       out_ready;
    logic [NUM_COLS*DATA_W-1:0] out_data;
    logic [NUM_COLS-1:0]        out_mask;
    logic                       err;

    modport slave (
        input  desc_valid, desc, bank_rvalid, bank_rdata, out_ready,
        output desc_ready, out_valid, out_data, out_mask, err
    );

    modport master (
        output desc_valid, desc, bank_rvalid, bank_rdata, out_ready,
        input  desc_ready, out_valid, out_data, out_mask, err
    );
endinterface

// File: rtl/scpad_unswizzle_fifo.sv
// Small synchronous FIFO with wrap-bit pointers; head word is visible without a read strobe.
module scpad_unswizzle_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_empty,
    output logic             o_full
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_empty;
    logic             w_full;
    logic             w_push;
    logic             w_pop;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_push  = i_push && !w_full;
    assign w_pop   = i_pop && !w_empty;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    // Empty FIFO presents zeros so downstream never sees stale storage.
    assign o_rdata = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
    assign o_empty = w_empty;
    assign o_full  = w_full;
endmodule

// File: rtl/scpad_unswizzle.sv
// Un-permutes in-order bank read returns into logical lane order and queues them for the consumer.
// Optional SCPAD_UNSWZ_CHECK_EN adds a sticky protocol error flag (stray return, bank conflict).
module scpad_unswizzle
    import scpad_unswizzle_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    scpad_unswizzle_if.slave  io_bus
);
    localparam int          AW      = $clog2(DEPTH);
    localparam int          DESC_W  = $bits(xbar_desc_t);
    localparam int          ROW_W   = NUM_COLS * DATA_W;
    localparam int          OUT_W   = ROW_W + NUM_COLS;
    localparam logic [AW:0] CREDITS = (AW+1)'(DEPTH);

    logic [AW:0]        r_count;
    logic               w_desc_ready;
    logic               w_issue;
    logic               w_ret;
    logic               w_out_fire;
    logic               w_desc_empty;
    logic               w_desc_full;
    logic               w_out_empty;
    logic               w_out_full;
    logic [DESC_W-1:0]  w_head_bits;
    xbar_desc_t         w_head;
    logic [DATA_W-1:0]  w_bank_word [NUM_COLS];
    logic [ROW_W-1:0]   w_lanes;
    logic [OUT_W-1:0]   w_out_word;
    logic               w_unused;

    // Credits cover both queues, so a return can always land in the output FIFO.
    assign w_desc_ready = (r_count < CREDITS);
    assign w_issue      = io_bus.desc_valid && w_desc_ready;
    assign w_ret        = io_bus.bank_rvalid && !w_desc_empty;
    assign w_out_fire   = !w_out_empty && io_bus.out_ready;
    assign w_head       = w_head_bits;

    scpad_unswizzle_fifo #(.WIDTH(DESC_W), .DEPTH(DEPTH)) u_desc_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_issue),
        .i_wdata (io_bus.desc),
        .i_pop   (w_ret),
        .o_rdata (w_head_bits),
        .o_empty (w_desc_empty),
        .o_full  (w_desc_full)
    );

    for (genvar gi = 0; gi < NUM_COLS; gi++) begin : g_lane
        assign w_bank_word[gi] = io_bus.bank_rdata[gi*DATA_W +: DATA_W];
        assign w_lanes[gi*DATA_W +: DATA_W] =
            w_head.valid_mask[gi] ? w_bank_word[w_head.shift_mask[gi]] : '0;
    end

    scpad_unswizzle_fifo #(.WIDTH(OUT_W), .DEPTH(DEPTH)) u_out_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_ret),
        .i_wdata ({w_head.valid_mask, w_lanes}),
        .i_pop   (w_out_fire),
        .o_rdata (w_out_word),
        .o_empty (w_out_empty),
        .o_full  (w_out_full)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (w_issue && !w_out_fire) begin
            r_count <= r_count + (AW+1)'(1);
        end else if (!w_issue && w_out_fire) begin
            r_count <= r_count - (AW+1)'(1);
        end
    end

    assign io_bus.desc_ready = w_desc_ready;
    assign io_bus.out_valid  = !w_out_empty;
    assign io_bus.out_data   = w_out_word[ROW_W-1:0];
    assign io_bus.out_mask   = w_out_word[OUT_W-1 -: NUM_COLS];

`ifdef SCPAD_UNSWZ_CHECK_EN
    logic r_err;
    logic w_conflict;

    assign w_conflict = !w_desc_empty && has_bank_conflict(w_head);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_err <= 1'b0;
        end else if ((io_bus.bank_rvalid && w_desc_empty) || w_conflict) begin
            r_err <= 1'b1;
        end
    end

    assign io_bus.err = r_err;
`else
    assign io_bus.err = 1'b0;
`endif

    // Slot indices and FIFO full flags are informational only on this path.
    assign w_unused = ^{w_head.slot_mask, w_desc_full, w_out_full};
endmodule

// File: tb/tb_scpad_unswizzle.sv
// Randomized and directed checks of scpad_unswizzle against a queue-based reference model.
module tb_scpad_unswizzle;
    import scpad_unswizzle_pkg::*;

    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int RW    = NUM_COLS * DW;
`ifdef SCPAD_UNSWZ_CHECK_EN
    localparam logic EXP_CHK = 1'b1;
`else
    localparam logic EXP_CHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    scpad_unswizzle_if #(.DATA_W(DW)) bus ();

    scpad_unswizzle #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (bus)
    );

    typedef struct {
        logic [RW-1:0]       data;
        logic [NUM_COLS-1:0] mask;
    } vec_t;

    xbar_desc_t dq[$];
    vec_t       oq[$];
    logic       m_err = 1'b0;
    int         n_checks = 0;
    int         n_fail   = 0;

    task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t expect_vec(input xbar_desc_t d, input logic [RW-1:0] rd);
        vec_t v;
        v.mask = d.valid_mask;
        v.data = '0;
        for (int i = 0; i < NUM_COLS; i++) begin
            if (d.valid_mask[i]) v.data[i*DW +: DW] = rd[int'(d.shift_mask[i])*DW +: DW];
        end
        return v;
    endfunction

    function automatic logic banks_collide(input xbar_desc_t d);
        int uses [NUM_COLS];
        logic hit;
        hit = 1'b0;
        for (int b = 0; b < NUM_COLS; b++) uses[b] = 0;
        for (int i = 0; i < NUM_COLS; i++) begin
            if (d.valid_mask[i]) uses[int'(d.shift_mask[i])]++;
        end
        for (int b = 0; b < NUM_COLS; b++) begin
            if (uses[b] > 1) hit = 1'b1;
        end
        return hit;
    endfunction

    // Reference: in-flight reads = queued descriptors + queued results, capped at DEPTH.
    always @(posedge clk or posedge rst) begin : model
        logic issue, ret, ofire;
        xbar_desc_t h;
        if (rst) begin
            dq.delete();
            oq.delete();
            m_err = 1'b0;
        end else begin
            issue = bus.desc_valid && ((dq.size() + oq.size()) < DEPTH);
            ret   = bus.bank_rvalid && (dq.size() != 0);
            ofire = bus.out_ready && (oq.size() != 0);
            if (EXP_CHK && ((bus.bank_rvalid && dq.size() == 0) ||
                            (dq.size() != 0 && banks_collide(dq[0])))) m_err = 1'b1;
            if (ofire) void'(oq.pop_front());
            if (ret) begin
                h = dq.pop_front();
                oq.push_back(expect_vec(h, bus.bank_rdata));
            end
            if (issue) dq.push_back(bus.desc);
        end
    end

    always @(negedge clk) begin
        check("desc_ready", bus.desc_ready, (dq.size() + oq.size()) < DEPTH);
        check("out_valid", bus.out_valid, oq.size() != 0);
        if (oq.size() != 0) begin
            check("out_data", bus.out_data, oq[0].data);
            check("out_mask", bus.out_mask, oq[0].mask);
        end
        check("err", bus.err, m_err);
    end

    function automatic xbar_desc_t mk_desc(input logic [NUM_COLS-1:0] vm, input int xorv);
        xbar_desc_t d;
        d.valid_mask = vm;
        for (int i = 0; i < NUM_COLS; i++) begin
            d.shift_mask[i] = col_idx_t'(i ^ xorv);
            d.slot_mask[i]  = row_idx_t'(i);
        end
        return d;
    endfunction

    function automatic logic [RW-1:0] ramp(input int base);
        logic [RW-1:0] r;
        for (int b = 0; b < NUM_COLS; b++) r[b*DW +: DW] = DW'(base + b);
        return r;
    endfunction

    function automatic logic [RW-1:0] rnd_row();
        logic [RW-1:0] r;
        for (int k = 0; k < RW / 32; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic drive(input logic dv, input xbar_desc_t d, input logic rv,
                         input logic [RW-1:0] rd, input logic ordy);
        bus.desc_valid  = dv;
        bus.desc        = d;
        bus.bank_rvalid = rv;
        bus.bank_rdata  = rd;
        bus.out_ready   = ordy;
        @(negedge clk);
    endtask

    task automatic flush();
        for (int k = 0; k < 20 && (dq.size() + oq.size()) != 0; k++) begin
            drive(1'b0, '0, dq.size() != 0, rnd_row(), 1'b1);
        end
        check("flush_empty", bus.out_valid, 1'b0);
    endtask

    initial begin
        xbar_desc_t d;
        drive(1'b0, '0, 1'b0, '0, 1'b0);
        check("rst_desc_ready", bus.desc_ready, 1'b1);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_out_data", bus.out_data, '0);
        check("rst_out_mask", bus.out_mask, '0);
        check("rst_err", bus.err, 1'b0);
        rst = 1'b0;

        // Row-major read, bank b returns 0x100+b
        drive(1'b1, mk_desc(16'hFFFF, 3), 1'b0, '0, 1'b0);
        drive(1'b0, '0, 1'b1, ramp(16'h100), 1'b0);
        check("rm_valid", bus.out_valid, 1'b1);
        check("rm_lane0", bus.out_data[0 +: 16], 16'h103);
        check("rm_lane5", bus.out_data[5*16 +: 16], 16'h106);
        check("rm_lane15", bus.out_data[15*16 +: 16], 16'h10C);
        check("rm_mask", bus.out_mask, 16'hFFFF);
        drive(1'b0, '0, 1'b0, '0, 1'b1);
        check("rm_drained", bus.out_valid, 1'b0);

        // Column read, lanes 0..7 only
        drive(1'b1, mk_desc(16'h00FF, 5), 1'b0, '0, 1'b0);
        drive(1'b0, '0, 1'b1, ramp(16'h200), 1'b0);
        check("col_lane0", bus.out_data[0 +: 16], 16'h205);
        check("col_lane3", bus.out_data[3*16 +: 16], 16'h206);
        check("col_lane7", bus.out_data[7*16 +: 16], 16'h202);
        check("col_lane8", bus.out_data[8*16 +: 16], 16'h000);
        check("col_mask", bus.out_mask, 16'h00FF);
        drive(1'b0, '0, 1'b0, '0, 1'b1);

        // Credit limit
        for (int k = 0; k < 4; k++) drive(1'b1, mk_desc(16'hFFFF, k), 1'b0, '0, 1'b0);
        check("cr_full", bus.desc_ready, 1'b0);
        drive(1'b1, mk_desc(16'hFFFF, 9), 1'b0, '0, 1'b0);
        check("cr_5th", bus.desc_ready, 1'b0);
        for (int k = 0; k < 4; k++) drive(1'b0, '0, 1'b1, ramp(16'h400 + k*16), 1'b0);
        check("cr_after_ret", bus.desc_ready, 1'b0);
        drive(1'b0, '0, 1'b0, '0, 1'b1);
        check("cr_one_fire", bus.desc_ready, 1'b1);
        drive(1'b1, mk_desc(16'hFFFF, 1), 1'b0, '0, 1'b1);
        check("cr_both", bus.desc_ready, 1'b1);
        drive(1'b1, mk_desc(16'hFFFF, 2), 1'b0, '0, 1'b0);
        check("cr_refill", bus.desc_ready, 1'b0);
        flush();

        // Back-to-back issue and return
        for (int k = 0; k < 4; k++) drive(1'b1, mk_desc(16'hFFFF, 0), 1'b0, '0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, '0, 1'b1, ramp(16'h300 + k*16), 1'b1);
            check("b2b_valid", bus.out_valid, 1'b1);
            check("b2b_lane0", bus.out_data[0 +: 16], 16'(16'h300 + k*16));
        end
        drive(1'b0, '0, 1'b0, '0, 1'b1);
        check("b2b_empty", bus.out_valid, 1'b0);

        // Stray return, then return racing the issue of an empty queue
        drive(1'b0, '0, 1'b1, rnd_row(), 1'b0);
        check("stray_no_out", bus.out_valid, 1'b0);
        check("stray_err", bus.err, EXP_CHK);
        drive(1'b1, mk_desc(16'hFFFF, 0), 1'b1, rnd_row(), 1'b0);
        check("simul_drop", bus.out_valid, 1'b0);
        drive(1'b0, '0, 1'b1, ramp(16'h500), 1'b0);
        check("simul_later", bus.out_data[0 +: 16], 16'h500);
        flush();

        // Bank conflict in head descriptor
        rst = 1'b1;
        drive(1'b0, '0, 1'b0, '0, 1'b0);
        rst = 1'b0;
        check("clr_err", bus.err, 1'b0);
        d = mk_desc(16'hFFFF, 0);
        d.shift_mask[1] = col_idx_t'(0);
        drive(1'b1, d, 1'b0, '0, 1'b0);
        drive(1'b0, '0, 1'b0, '0, 1'b0);
        check("conflict_err", bus.err, EXP_CHK);
        flush();

        // Asynchronous reset with reads in flight
        for (int k = 0; k < 4; k++) drive(1'b1, mk_desc(16'hFFFF, k), 1'b0, '0, 1'b0);
        drive(1'b0, '0, 1'b1, ramp(16'h600), 1'b0);
        check("pre_rst_ready", bus.desc_ready, 1'b0);
        check("pre_rst_valid", bus.out_valid, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_valid", bus.out_valid, 1'b0);
        check("rst_mid_ready", bus.desc_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, '0, 1'b1, rnd_row(), 1'b0);
        check("late_ret", bus.out_valid, 1'b0);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            d = mk_desc(NUM_COLS'($urandom), int'($urandom_range(0, 15)));
            if ($urandom_range(0, 3) == 0) d.shift_mask[$urandom_range(0, 15)] = col_idx_t'($urandom_range(0, 15));
            drive(1'($urandom_range(0, 1)), d, $urandom_range(0, 9) < 4, rnd_row(), $urandom_range(0, 9) < 6);
        end
        flush();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
